// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
//   Upstream control stage for the 16x16 register file / ALU datapath.
//   Instructions are loaded into a small program buffer over a valid/ready
//   port. A run pulse replays them in order. Each instruction takes one
//   ISSUE cycle, where addresses and op are registered, and one WRITE
//   cycle, where the write strobe fires and the ALU result is captured.
//
// Optional build macro: SEQ_SINGLE_STEP_EN
//   Adds a 'step' input and a PAUSE state between instructions.
//
// Ports:
//   CLOCK_50, RESET          clock (rising edge), synchronous active-high reset
//   load_valid/instr/ready   program load handshake (accepted only in IDLE)
//   run, clear               start/replay execution, empty the buffer
//   step                     (SEQ_SINGLE_STEP_EN only) advance out of PAUSE
//   alu_result               combinational ALU output, captured in WRITE
//   rf_a/b/wr_addr, rf_write register-file addresses and write strobe
//   alu_op, alu_cin          ALU controls
//   last_result              ALU result captured at the most recent WRITE
//   count, busy, done        buffer fill level and execution status
module regfile_op_sequencer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             load_valid,
  input  logic [18:0]      load_instr,
  output logic             load_ready,
  input  logic             run,
  input  logic             clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [15:0]      alu_result,
  output logic [3:0]       rf_a_addr,
  output logic [3:0]       rf_b_addr,
  output logic [3:0]       rf_wr_addr,
  output logic             rf_write,
  output logic [4:0]       alu_op,
  output logic             alu_cin,
  output logic [15:0]      last_result,
  output logic [PTR_W:0]   count,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [3:0] wr_addr;
    logic [3:0] a_addr;
    logic [3:0] b_addr;
    logic [4:0] alu_op;
    logic       alu_cin;
    logic       wr_en;
  } instr_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [2:0]       state;
  logic [PTR_W-1:0] pc;
  logic [PTR_W-1:0] fetch_idx;
  logic             last_instr;
  instr_t           prog_mem [DEPTH];
  instr_t           fetch;

  assign load_ready = (state == S_IDLE) && (count < FULL) && !run && !clear;
  assign busy       = (state == S_ISSUE) || (state == S_WRITE) || (state == S_PAUSE);
  assign done       = (state == S_DONE);
  assign last_instr = ({1'b0, pc} == count - 1'b1);

  // Fields are registered on entry to ISSUE, so the fetch index is the pc
  // the FSM is about to hold. From WRITE that is the next instruction.
  // From PAUSE, pc has already advanced. From IDLE/DONE a run starts at 0.
  always_comb begin
    fetch_idx = '0;
    case (state)
      S_WRITE: fetch_idx = pc + 1'b1;
      S_PAUSE: fetch_idx = pc;
      default: fetch_idx = '0;
    endcase
  end
  assign fetch = prog_mem[fetch_idx];

  // The program buffer has no reset; count alone defines the valid entries.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET && load_valid && load_ready)
      prog_mem[count[PTR_W-1:0]] <= instr_t'(load_instr);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state       <= S_IDLE;
      count       <= '0;
      pc          <= '0;
      rf_a_addr   <= '0;
      rf_b_addr   <= '0;
      rf_wr_addr  <= '0;
      alu_op      <= '0;
      alu_cin     <= 1'b0;
      rf_write    <= 1'b0;
      last_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (run) begin
            if (count != '0) begin
              pc         <= '0;
              rf_a_addr  <= fetch.a_addr;
              rf_b_addr  <= fetch.b_addr;
              rf_wr_addr <= fetch.wr_addr;
              alu_op     <= fetch.alu_op;
              alu_cin    <= fetch.alu_cin;
              state      <= S_ISSUE;
            end
          end else if (load_valid && load_ready) begin
            count <= count + 1'b1;
          end
        end
        S_ISSUE: begin
          rf_write <= prog_mem[pc].wr_en;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          rf_write    <= 1'b0;
          last_result <= alu_result;
          if (last_instr) begin
            state <= S_DONE;
          end else begin
            pc <= pc + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            state <= S_PAUSE;
`else
            rf_a_addr  <= fetch.a_addr;
            rf_b_addr  <= fetch.b_addr;
            rf_wr_addr <= fetch.wr_addr;
            alu_op     <= fetch.alu_op;
            alu_cin    <= fetch.alu_cin;
            state      <= S_ISSUE;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) begin
            rf_a_addr  <= fetch.a_addr;
            rf_b_addr  <= fetch.b_addr;
            rf_wr_addr <= fetch.wr_addr;
            alu_op     <= fetch.alu_op;
            alu_cin    <= fetch.alu_cin;
            state      <= S_ISSUE;
          end
        end
`endif
        S_DONE: begin
          if (clear) begin
            count <= '0;
            state <= S_IDLE;
          end else if (run) begin
            pc         <= '0;
            rf_a_addr  <= fetch.a_addr;
            rf_b_addr  <= fetch.b_addr;
            rf_wr_addr <= fetch.wr_addr;
            alu_op     <= fetch.alu_op;
            alu_cin    <= fetch.alu_cin;
            state      <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed testbench for regfile_op_sequencer. Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, so a value
// seen after edge e is what the datapath samples at edge e+1.
module tb_regfile_op_sequencer;
  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        load_valid = 1'b0;
  logic [18:0] load_instr = '0;
  logic        load_ready;
  logic        run = 1'b0;
  logic        clear = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [15:0] alu_result = '0;
  logic [3:0]  rf_a_addr, rf_b_addr, rf_wr_addr;
  logic        rf_write;
  logic [4:0]  alu_op;
  logic        alu_cin;
  logic [15:0] last_result;
  logic [3:0]  count;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  regfile_op_sequencer #(.DEPTH(8), .PTR_W(3)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .load_valid(load_valid), .load_instr(load_instr), .load_ready(load_ready),
    .run(run), .clear(clear),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .alu_result(alu_result),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_wr_addr(rf_wr_addr),
    .rf_write(rf_write), .alu_op(alu_op), .alu_cin(alu_cin),
    .last_result(last_result), .count(count), .busy(busy), .done(done)
  );

  function automatic logic [18:0] enc(input logic [3:0] wr, input logic [3:0] a,
                                      input logic [3:0] b, input logic [4:0] op,
                                      input logic cin, input logic we);
    return {wr, a, b, op, cin, we};
  endfunction

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic load_word(input logic [18:0] w);
    load_valid = 1'b1;
    load_instr = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    total++;
    if ({count, busy, done, rf_write, last_result} !== 23'd0) begin
      bad++;
      $display("FAIL reset_status got count=%0d busy=%0b done=%0b wr=%0b last=%h want all 0",
               count, busy, done, rf_write, last_result);
    end
    total++;
    if ({rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin} !== 18'd0) begin
      bad++;
      $display("FAIL reset_addr got a=%0d b=%0d wr=%0d op=%0d cin=%0b want 0",
               rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin);
    end
  endtask

  task automatic test_load3;
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_instr = enc(4'(i), 4'(i), 4'(i), 5'(i), 1'b0, 1'b1);
      total++;
      if (load_ready !== 1'b1) begin
        bad++;
        $display("FAIL load3_ready[%0d] got %b want 1", i, load_ready);
      end
      tick();
    end
    load_valid = 1'b0;
    total++;
    if (count !== 4'd3 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL load3_status got count=%0d busy=%b done=%b want 3/0/0", count, busy, done);
    end
    do_clear();
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL clear_idle got count=%0d want 0", count);
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) load_word(enc(4'(i), 4'(i + 1), 4'(i + 2), 5'(i), 1'b0, 1'b1));
    load_valid = 1'b1;
    load_instr = enc(4'hF, 4'hF, 4'hF, 5'h1F, 1'b1, 1'b1);
    #1;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got %b want 0", load_ready);
    end
    tick();
    load_valid = 1'b0;
    total++;
    if (count !== 4'd8) begin
      bad++;
      $display("FAIL full_count got %0d want 8", count);
    end
    // Replay to show the buffer still holds the original 8 words.
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rf_a_addr !== 4'(i + 1) || rf_b_addr !== 4'(i + 2) || alu_op !== 5'(i)) begin
        bad++;
        $display("FAIL full_issue[%0d] got a=%0d b=%0d op=%0d want %0d/%0d/%0d",
                 i, rf_a_addr, rf_b_addr, alu_op, i + 1, i + 2, i);
      end
      tick();
      total++;
      if (rf_write !== 1'b1 || rf_wr_addr !== 4'(i)) begin
        bad++;
        $display("FAIL full_write[%0d] got wr=%b addr=%0d want 1/%0d", i, rf_write, rf_wr_addr, i);
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL full_done got %b want 1", done);
    end
    do_clear();
  endtask

  // Runs the 2-instruction program already in the buffer; run sampled at edge k.
  task automatic run_two(input string tag);
    alu_result = 16'h00AB;
    run = 1'b1;
    tick();                               // edge k
    run = 1'b0;
    total++;
    if (busy !== 1'b1 || rf_write !== 1'b0 || rf_a_addr !== 4'd1 || rf_b_addr !== 4'd2 || alu_op !== 5'd3) begin
      bad++;
      $display("FAIL %s_issue1 got busy=%b wr=%b a=%0d b=%0d op=%0d want 1/0/1/2/3",
               tag, busy, rf_write, rf_a_addr, rf_b_addr, alu_op);
    end
    tick();                               // edge k+1
    total++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 4'd5) begin
      bad++;
      $display("FAIL %s_write1 got wr=%b addr=%0d want 1/5", tag, rf_write, rf_wr_addr);
    end
    tick();                               // edge k+2
    alu_result = 16'h1234;
    total++;
    if (rf_write !== 1'b0 || last_result !== 16'h00AB || rf_wr_addr !== 4'd6 || alu_cin !== 1'b1) begin
      bad++;
      $display("FAIL %s_issue2 got wr=%b last=%h addr=%0d cin=%b want 0/00ab/6/1",
               tag, rf_write, last_result, rf_wr_addr, alu_cin);
    end
    tick();                               // edge k+3
    total++;
    if (rf_write !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s_write2 got wr=%b busy=%b done=%b want 0/1/0", tag, rf_write, busy, done);
    end
    tick();                               // edge k+4
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || last_result !== 16'h1234 || rf_write !== 1'b0 || rf_wr_addr !== 4'd6) begin
      bad++;
      $display("FAIL %s_done got done=%b busy=%b last=%h wr=%b addr=%0d want 1/0/1234/0/6",
               tag, done, busy, last_result, rf_write, rf_wr_addr);
    end
  endtask

  task automatic test_two_instr;
    load_word(enc(4'd5, 4'd1, 4'd2, 5'd3, 1'b0, 1'b1));
    load_word(enc(4'd6, 4'd5, 4'd5, 5'd1, 1'b1, 1'b0));
    run_two("prog");
  endtask

  task automatic test_replay;
    run_two("replay");
    clear = 1'b1;
    run = 1'b1;
    tick();
    clear = 1'b0;
    run = 1'b0;
    tick();
    total++;
    if (count !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_clear_run got count=%0d done=%b busy=%b want 0/0/0", count, done, busy);
    end
  endtask

  task automatic test_empty_run;
    int seen;
    seen = 0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rf_write || busy) seen++;
    end
    run = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL empty_run got %0d active cycles want 0", seen);
    end
    clear = 1'b1;
    load_valid = 1'b1;
    load_instr = enc(4'd1, 4'd1, 4'd1, 5'd1, 1'b0, 1'b1);
    #1;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_load_ready got %b want 0", load_ready);
    end
    tick();
    clear = 1'b0;
    load_valid = 1'b0;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL clear_load_count got %0d want 0", count);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) load_word(enc(4'(i + 8), 4'(i), 4'(i), 5'(i + 1), 1'b1, 1'b1));
    alu_result = 16'hBEEF;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();                               // WRITE of instruction 2 visible
    total++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 4'd9) begin
      bad++;
      $display("FAIL mid_write2 got wr=%b addr=%0d want 1/9", rf_write, rf_wr_addr);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    total++;
    if ({count, busy, done, rf_write, last_result, rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin} !== 41'd0) begin
      bad++;
      $display("FAIL mid_reset got count=%0d busy=%b done=%b wr=%b last=%h a=%0d b=%0d wa=%0d op=%0d cin=%b want 0",
               count, busy, done, rf_write, last_result, rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_write) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL mid_no_pulse got %0d pulses want 0", pulses);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_step;
    int pulses;
    pulses = 0;
    load_word(enc(4'd3, 4'd1, 4'd1, 5'd2, 1'b0, 1'b1));
    load_word(enc(4'd4, 4'd2, 4'd2, 5'd2, 1'b0, 1'b1));
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();                               // now in PAUSE
    for (int i = 0; i < 5; i++) begin
      if (rf_write) pulses++;
      tick();
    end
    total++;
    if (pulses != 0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL step_pause got pulses=%0d busy=%b done=%b want 0/1/0", pulses, busy, done);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    total++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 4'd4) begin
      bad++;
      $display("FAIL step_write2 got wr=%b addr=%0d want 1/4", rf_write, rf_wr_addr);
    end
    tick();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL step_done got %b want 1", done);
    end
    do_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_load3();
    test_full();
    test_two_instr();
    test_replay();
    test_empty_run();
    test_reset_mid();
`ifdef SEQ_SINGLE_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Upstream control stage for the 16x16 register file and ALU datapath.
- Replaces hand-set switch fields with a small buffered micro-program.
- Instructions are loaded over a valid/ready port. On a run pulse the block replays them in order, driving register-file read/write addresses, ALU op/carry and the write strobe, and captures each ALU result.

Parameters:
- DEPTH, 8: program buffer entries (power of two, 2..16).
- PTR_W, 3: log2(DEPTH).

Ports:
- CLOCK_50, in, 1: system clock, rising edge.
- RESET, in, 1: synchronous, active-high reset.
- load_valid, in, 1: load_instr is valid.
- load_instr, in, 19: instruction word. Fields: [18:15] wr_addr, [14:11] a_addr, [10:7] b_addr, [6:2] alu_op, [1] alu_cin, [0] wr_en.
- load_ready, out, 1: buffer accepts a word this cycle.
- run, in, 1: start execution (level sampled each cycle).
- clear, in, 1: empty the buffer.
- alu_result, in, 16: combinational ALU output.
- rf_a_addr, out, 4: register-file read port A address.
- rf_b_addr, out, 4: register-file read port B address.
- rf_wr_addr, out, 4: register-file write address.
- rf_write, out, 1: register-file write enable (one-cycle pulse).
- alu_op, out, 5: ALU operation select (opaque to this block).
- alu_cin, out, 1: ALU carry-in.
- last_result, out, 16: ALU result captured at the most recent WRITE.
- count, out, PTR_W+1: number of loaded instructions.
- busy, out, 1: state is ISSUE or WRITE.
- done, out, 1: state is DONE.

Behaviour:
- Reset:
  - state=IDLE; count=0; pc=0.
  - rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin, rf_write, last_result all 0.
  - busy=0, done=0. Buffer contents are don't-care.
- load_ready = (state==IDLE) && (count<DEPTH) && !run && !clear. Combinational.
- IDLE:
  - load_valid && load_ready: buf[count] <= load_instr; count++.
  - Full (count==DEPTH): load_ready=0; the offered word is not consumed.
  - Precedence: clear > run > load. clear sets count=0 and stays IDLE.
  - run with count>0: pc=0, go to ISSUE.
  - run with count==0: ignored, stay IDLE.
- ISSUE (1 cycle):
  - On entry, register the fields of buf[pc] onto rf_a_addr, rf_b_addr, rf_wr_addr, alu_op, alu_cin.
  - rf_write=0. Go to WRITE.
- WRITE (1 cycle):
  - rf_write = wr_en field of buf[pc]. Address and op outputs hold.
  - last_result <= alu_result, regardless of wr_en.
  - If pc==count-1: go to DONE. Otherwise pc++ and go to ISSUE.
- DONE:
  - done=1; address and op outputs hold the last instruction; rf_write=0.
  - run: pc=0, go to ISSUE (replays the program; buffer is kept).
  - clear: count=0, go to IDLE.
  - Both asserted: clear wins.
- Latency: run sampled at edge k gives ISSUE at k+1 and the first rf_write at k+2. For N instructions, done rises at edge k+2N+1.
- run, clear and load_valid are ignored while busy. There is no abort path; only RESET interrupts execution.
- RESET mid-execution: returns to the reset state immediately. The buffer is emptied (count=0) and no further rf_write pulses occur.
- Read-after-write across consecutive instructions is safe: the write happens at the WRITE edge, and the next instruction's operands are read in its ISSUE cycle.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After each WRITE that does not finish the program, the FSM enters a PAUSE state with busy=1.
  - A step pulse moves PAUSE to ISSUE; run and clear are ignored in PAUSE.
  - The first instruction still starts from run.
- Undefined:
  - No step port and no PAUSE state.
  - Execution is continuous as described in Behaviour.

Test Plan:
- Reset, then load 3 words with load_valid held -> load_ready=1 each cycle; count=3; done=0; busy=0.
- Load 8 words, then offer a 9th -> load_ready=0 on the 9th cycle; count stays 8; buffer contents unchanged.
- Load {wr=5,a=1,b=2,op=3,cin=0,wr_en=1} and {wr=6,a=5,b=5,op=1,cin=1,wr_en=0}, drive alu_result=16'h00AB then 16'h1234, pulse run at edge k:
  - rf_write=1 with rf_wr_addr=5 at k+2 only.
  - last_result=16'h1234 after k+4.
  - done=1 at k+5.
- run with count=0 -> state stays IDLE; busy=0; rf_write never asserts. Then assert clear and load_valid together in IDLE -> load_ready=0 and count=0.
- In DONE, pulse run -> replay with an identical rf_write sequence. Then assert clear and run together -> IDLE with count=0.
- Assert RESET at the WRITE cycle of instruction 2 of 4 -> next cycle all outputs are 0 and count=0; no further rf_write pulses.
- With SEQ_SINGLE_STEP_EN defined, load 2 instructions and pulse run -> PAUSE after the first WRITE; no second rf_write until step; done follows the second WRITE.
